cpu_irq_ctrl: RTL and testbench

- Parametrised interrupt/exception controller; next generation after the single-bit Interrupt/Exception control path.
- Accepts NUM_IRQ maskable interrupt lines and a decoder exception request, prioritises them, and synchronises entry with the pipeline commit point.
- Captures EPC and a cause code, drives the PC redirect to the handler vector, and tracks handler residency until eret.
- Sits beside CPU_Control; its take pulse drives that decoder's Interrupt/Exception inputs and the PC mux.

---
 rtl/cpu_irq_pkg.sv | 20 ++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/cpu_irq_ctrl.sv | 145 ++++++++++++++
 tb/tb_cpu_irq_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_irq_pkg.sv
// Shared types and constants for the cpu_irq_ctrl interrupt/exception controller.
package cpu_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [31:0] IRQ_VECTOR_DEF = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0008;

    localparam int CAUSE_W    = 8;
    localparam int EXC_CODE_W = 5;

    // cause[7] flags an exception; cause[6:0] carries the code or IRQ index
    localparam int CAUSE_EXC_BIT = 7;
    localparam int CAUSE_IDX_MSB = 6;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the registered pending vector.
module irq_prio_enc #(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [6:0]         index
);

    // Scanning downward lets the lowest set bit overwrite any higher one
    always_comb begin
        valid = 1'b0;
        index = 7'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = 7'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_irq_ctrl.sv
// Interrupt/exception entry and return controller synchronised to the commit point.
// Build option IRQ_EDGE_EN switches the IRQ lines from level to rising-edge capture.
module cpu_irq_ctrl
    import cpu_irq_pkg::*;
#(
    parameter int                 NUM_IRQ    = 4,
    parameter logic [NUM_IRQ-1:0] MASK_RST   = '1,
    parameter logic [31:0]        IRQ_VECTOR = IRQ_VECTOR_DEF,
    parameter logic [31:0]        EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_IRQ-1:0]    irq_in,
    input  logic                  exc_req,
    input  logic [EXC_CODE_W-1:0] exc_code,
    input  logic                  commit_valid,
    input  logic [31:0]           pc_cur,
    input  logic                  eret,
    input  logic                  mask_wr,
    input  logic [NUM_IRQ-1:0]    mask_wdata,
    output logic                  take,
    output logic [31:0]           take_vector,
    output logic [31:0]           epc,
    output logic [CAUSE_W-1:0]    cause,
    output logic                  in_service,
    output logic [NUM_IRQ-1:0]    irq_mask,
    output logic [NUM_IRQ-1:0]    irq_pending,
    output logic                  ret_valid,
    output logic [31:0]           ret_pc,
    output logic                  fault
);

    state_t                  state;
    logic                    exc_pend;
    logic [EXC_CODE_W-1:0]   exc_code_q;
    logic                    prio_valid;
    logic [6:0]              prio_index;
    logic                    irq_eligible;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req   (irq_pending),
        .valid (prio_valid),
        .index (prio_index)
    );

    // Interrupts only preempt user-mode code (pc_cur[31] clear)
    assign irq_eligible = prio_valid && !pc_cur[31];

`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] take_clr;

    always_comb begin
        take_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            take_clr[i] = (state == TAKE) && !cause[CAUSE_EXC_BIT] &&
                          (cause[CAUSE_IDX_MSB:0] == 7'(i));
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask    <= MASK_RST;
            irq_pending <= '0;
`ifdef IRQ_EDGE_EN
            irq_q       <= '0;
`endif
        end else begin
            if (mask_wr) begin
                irq_mask <= mask_wdata;
            end
`ifdef IRQ_EDGE_EN
            irq_q       <= irq_in;
            irq_pending <= (irq_pending & ~take_clr) | (irq_in & ~irq_q & irq_mask);
`else
            irq_pending <= irq_in & irq_mask;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            take        <= 1'b0;
            take_vector <= '0;
            epc         <= '0;
            cause       <= '0;
            in_service  <= 1'b0;
            ret_valid   <= 1'b0;
            ret_pc      <= '0;
            fault       <= 1'b0;
            exc_pend    <= 1'b0;
            exc_code_q  <= '0;
        end else begin
            take        <= 1'b0;
            take_vector <= '0;
            ret_valid   <= 1'b0;
            ret_pc      <= '0;

            case (state)
                IDLE: begin
                    if (commit_valid && exc_pend) begin
                        state       <= TAKE;
                        take        <= 1'b1;
                        take_vector <= EXC_VECTOR;
                        epc         <= pc_cur + 32'd4;
                        cause       <= {1'b1, {(CAUSE_W-1-EXC_CODE_W){1'b0}}, exc_code_q};
                        exc_pend    <= 1'b0;
                    end else if (commit_valid && irq_eligible) begin
                        state       <= TAKE;
                        take        <= 1'b1;
                        take_vector <= IRQ_VECTOR;
                        epc         <= pc_cur;
                        cause       <= {1'b0, prio_index};
                    end
                end
                TAKE: begin
                    state      <= SERVICE;
                    in_service <= 1'b1;
                end
                SERVICE: begin
                    if (eret) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                        ret_valid  <= 1'b1;
                        ret_pc     <= epc;
                    end
                end
                default: state <= IDLE;
            endcase

            // A fresh request in IDLE overrides the clear above; outside IDLE it is a double fault
            if (exc_req) begin
                if (state == IDLE) begin
                    exc_pend   <= 1'b1;
                    exc_code_q <= exc_code;
                end else begin
                    fault <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Scoreboard testbench for cpu_irq_ctrl; build with IRQ_EDGE_EN to exercise edge capture.
module tb_cpu_irq_ctrl;

    localparam int NUM_IRQ = 4;
    localparam logic [31:0] IVEC = 32'h8000_0004;
    localparam logic [31:0] EVEC = 32'h8000_0008;

    typedef struct {
        logic [31:0] vec;
        logic [31:0] epc;
        logic [7:0]  cause;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_IRQ-1:0] irq_in;
    logic               exc_req;
    logic [4:0]         exc_code;
    logic               commit_valid;
    logic [31:0]        pc_cur;
    logic               eret;
    logic               mask_wr;
    logic [NUM_IRQ-1:0] mask_wdata;
    logic               take;
    logic [31:0]        take_vector;
    logic [31:0]        epc;
    logic [7:0]         cause;
    logic               in_service;
    logic [NUM_IRQ-1:0] irq_mask;
    logic [NUM_IRQ-1:0] irq_pending;
    logic               ret_valid;
    logic [31:0]        ret_pc;
    logic               fault;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    cpu_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq_in),
        .exc_req      (exc_req),
        .exc_code     (exc_code),
        .commit_valid (commit_valid),
        .pc_cur       (pc_cur),
        .eret         (eret),
        .mask_wr      (mask_wr),
        .mask_wdata   (mask_wdata),
        .take         (take),
        .take_vector  (take_vector),
        .epc          (epc),
        .cause        (cause),
        .in_service   (in_service),
        .irq_mask     (irq_mask),
        .irq_pending  (irq_pending),
        .ret_valid    (ret_valid),
        .ret_pc       (ret_pc),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        irq_in       = '0;
        exc_req      = 1'b0;
        exc_code     = '0;
        commit_valid = 1'b0;
        pc_cur       = '0;
        eret         = 1'b0;
        mask_wr      = 1'b0;
        mask_wdata   = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_take(input int budget, output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            step();
            cycles++;
            if (take === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic finish_service();
        irq_in       = '0;
        commit_valid = 1'b0;
        step();
        eret = 1'b1;
        step();
        eret = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (take !== 1'b0 || take_vector !== 32'h0 || in_service !== 1'b0 || ret_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctl: take=%b vec=%h insvc=%b retv=%b required 0", take, take_vector, in_service, ret_valid);
        end
        total++;
        if (epc !== 32'h0 || cause !== 8'h00 || ret_pc !== 32'h0 || fault !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_regs: epc=%h cause=%h retpc=%h fault=%b required 0", epc, cause, ret_pc, fault);
        end
        total++;
        if (irq_mask !== 4'hF || irq_pending !== 4'h0) begin
            bad++;
            $display("[TB] FAIL reset_mask: mask=%h pend=%h required F/0", irq_mask, irq_pending);
        end
    endtask

    task automatic test_irq_entry();
        bit seen; int cyc; exp_t e;
        do_reset();
        irq_in = 4'b0100; pc_cur = 32'h0040_0010; commit_valid = 1'b1;
        sb.push_back('{IVEC, 32'h0040_0010, 8'h02});
        wait_take(6, seen, cyc);
        e = sb.pop_front();
        total++;
        if (!seen || cyc != 2) begin
            bad++; $display("[TB] FAIL irq_latency: seen=%b cycles=%0d required 1/2", seen, cyc);
        end
        total++;
        if (take_vector !== e.vec || epc !== e.epc || cause !== e.cause) begin
            bad++;
            $display("[TB] FAIL irq_take: vec=%h epc=%h cause=%h required %h/%h/%h", take_vector, epc, cause, e.vec, e.epc, e.cause);
        end
        irq_in = '0; commit_valid = 1'b0;
        step();
        total++;
        if (in_service !== 1'b1 || take !== 1'b0) begin
            bad++; $display("[TB] FAIL irq_service: insvc=%b take=%b required 1/0", in_service, take);
        end
        eret = 1'b1;
        step();
        eret = 1'b0;
        total++;
        if (ret_valid !== 1'b1 || ret_pc !== 32'h0040_0010 || in_service !== 1'b0) begin
            bad++; $display("[TB] FAIL irq_eret: retv=%b retpc=%h insvc=%b required 1/00400010/0", ret_valid, ret_pc, in_service);
        end
    endtask

    task automatic test_exc_priority();
        bit seen; int cyc; exp_t e;
        do_reset();
        exc_req = 1'b1; exc_code = 5'h0A; irq_in = 4'b0001;
        pc_cur = 32'h0040_0020; commit_valid = 1'b1;
        sb.push_back('{EVEC, 32'h0040_0024, 8'h8A});
        step();
        exc_req = 1'b0;
        wait_take(5, seen, cyc);
        e = sb.pop_front();
        total++;
        if (!seen || take_vector !== e.vec || epc !== e.epc || cause !== e.cause) begin
            bad++;
            $display("[TB] FAIL exc_take: seen=%b vec=%h epc=%h cause=%h required %h/%h/%h", seen, take_vector, epc, cause, e.vec, e.epc, e.cause);
        end
        step();
        total++;
        if (irq_pending !== 4'b0001) begin
            bad++; $display("[TB] FAIL exc_irq_held: pend=%b required 0001", irq_pending);
        end
        sb.push_back('{IVEC, 32'h0040_0020, 8'h00});
        eret = 1'b1;
        step();
        eret = 1'b0;
        total++;
        if (ret_valid !== 1'b1 || ret_pc !== 32'h0040_0024) begin
            bad++; $display("[TB] FAIL exc_eret: retv=%b retpc=%h required 1/00400024", ret_valid, ret_pc);
        end
        wait_take(5, seen, cyc);
        e = sb.pop_front();
        total++;
        if (!seen || cyc != 1 || cause !== e.cause || epc !== e.epc || take_vector !== e.vec) begin
            bad++;
            $display("[TB] FAIL reentry: seen=%b cyc=%0d cause=%h epc=%h vec=%h required 1/1/%h/%h/%h", seen, cyc, cause, epc, take_vector, e.cause, e.epc, e.vec);
        end
        finish_service();
    endtask

    task automatic test_kernel_mode();
        bit seen; int cyc; exp_t e;
        do_reset();
        irq_in = 4'b1000; pc_cur = 32'h8000_0100; commit_valid = 1'b1;
        wait_take(6, seen, cyc);
        total++;
        if (seen || irq_pending !== 4'b1000) begin
            bad++; $display("[TB] FAIL kernel_no_irq: seen=%b pend=%b required 0/1000", seen, irq_pending);
        end
        exc_req = 1'b1; exc_code = 5'h03;
        sb.push_back('{EVEC, 32'h8000_0104, 8'h83});
        step();
        exc_req = 1'b0;
        wait_take(5, seen, cyc);
        e = sb.pop_front();
        total++;
        if (!seen || take_vector !== e.vec || epc !== e.epc || cause !== e.cause) begin
            bad++;
            $display("[TB] FAIL kernel_exc: seen=%b vec=%h epc=%h cause=%h required %h/%h/%h", seen, take_vector, epc, cause, e.vec, e.epc, e.cause);
        end
        finish_service();
    endtask

    task automatic test_mask();
        bit seen; int cyc; exp_t e;
        do_reset();
        mask_wr = 1'b1; mask_wdata = 4'b1110;
        step();
        mask_wr = 1'b0;
        total++;
        if (irq_mask !== 4'b1110) begin
            bad++; $display("[TB] FAIL mask_write: mask=%b required 1110", irq_mask);
        end
        irq_in = 4'b0011; pc_cur = 32'h0040_0100; commit_valid = 1'b1;
        sb.push_back('{IVEC, 32'h0040_0100, 8'h01});
        wait_take(6, seen, cyc);
        e = sb.pop_front();
        total++;
        if (!seen || cause !== e.cause || epc !== e.epc || take_vector !== e.vec) begin
            bad++;
            $display("[TB] FAIL mask_take: seen=%b cause=%h epc=%h vec=%h required %h/%h/%h", seen, cause, epc, take_vector, e.cause, e.epc, e.vec);
        end
        finish_service();
`ifndef IRQ_EDGE_EN
        irq_in = 4'b0010;
        step();
        step();
        total++;
        if (irq_pending !== 4'b0010) begin
            bad++; $display("[TB] FAIL mask_pend: pend=%b required 0010", irq_pending);
        end
        mask_wr = 1'b1; mask_wdata = 4'b0000;
        step();
        mask_wr = 1'b0;
        step();
        total++;
        if (irq_pending !== 4'b0000 || irq_mask !== 4'b0000) begin
            bad++; $display("[TB] FAIL mask_zero: pend=%b mask=%b required 0000/0000", irq_pending, irq_mask);
        end
        commit_valid = 1'b1;
        wait_take(6, seen, cyc);
        total++;
        if (seen) begin
            bad++; $display("[TB] FAIL mask_block: take seen=%b required 0", seen);
        end
`endif
    endtask

    task automatic test_fault_and_reset();
        bit seen; int cyc; exp_t e;
        do_reset();
        irq_in = 4'b0100; pc_cur = 32'h0040_0040; commit_valid = 1'b1;
        sb.push_back('{IVEC, 32'h0040_0040, 8'h02});
        wait_take(6, seen, cyc);
        e = sb.pop_front();
        total++;
        if (!seen || cause !== e.cause || epc !== e.epc) begin
            bad++; $display("[TB] FAIL fault_entry: seen=%b cause=%h epc=%h required %h/%h", seen, cause, epc, e.cause, e.epc);
        end
        irq_in = '0;
        step();
        exc_req = 1'b1; exc_code = 5'h11;
        step();
        exc_req = 1'b0;
        step();
        total++;
        if (fault !== 1'b1 || in_service !== 1'b1) begin
            bad++; $display("[TB] FAIL fault_set: fault=%b insvc=%b required 1/1", fault, in_service);
        end
        eret = 1'b1;
        step();
        eret = 1'b0;
        total++;
        if (ret_valid !== 1'b1 || ret_pc !== 32'h0040_0040 || fault !== 1'b1) begin
            bad++; $display("[TB] FAIL fault_eret: retv=%b retpc=%h fault=%b required 1/00400040/1", ret_valid, ret_pc, fault);
        end
        irq_in = 4'b0001;
        sb.push_back('{IVEC, 32'h0040_0040, 8'h00});
        wait_take(6, seen, cyc);
        e = sb.pop_front();
        total++;
        if (!seen || cause !== e.cause || take_vector !== e.vec) begin
            bad++; $display("[TB] FAIL fault_dropped: seen=%b cause=%h vec=%h required 1/%h/%h", seen, cause, take_vector, e.cause, e.vec);
        end
        irq_in = '0; commit_valid = 1'b0;
        step();
        mask_wr = 1'b1; mask_wdata = 4'b0000;
        step();
        mask_wr = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (in_service !== 1'b0 || irq_mask !== 4'hF || fault !== 1'b0 || irq_pending !== 4'h0) begin
            bad++;
            $display("[TB] FAIL mid_reset: insvc=%b mask=%h fault=%b pend=%h required 0/F/0/0", in_service, irq_mask, fault, irq_pending);
        end
    endtask

`ifdef IRQ_EDGE_EN
    task automatic test_edge();
        bit seen; int cyc; exp_t e;
        do_reset();
        irq_in = 4'b0100;
        step();
        irq_in = '0;
        step();
        step();
        total++;
        if (irq_pending !== 4'b0100) begin
            bad++; $display("[TB] FAIL edge_hold: pend=%b required 0100", irq_pending);
        end
        pc_cur = 32'h0040_0200; commit_valid = 1'b1;
        sb.push_back('{IVEC, 32'h0040_0200, 8'h02});
        wait_take(5, seen, cyc);
        e = sb.pop_front();
        total++;
        if (!seen || cause !== e.cause || epc !== e.epc) begin
            bad++; $display("[TB] FAIL edge_take: seen=%b cause=%h epc=%h required %h/%h", seen, cause, epc, e.cause, e.epc);
        end
        step();
        total++;
        if (irq_pending !== 4'b0000) begin
            bad++; $display("[TB] FAIL edge_clear: pend=%b required 0000", irq_pending);
        end
        irq_in = 4'b0001;
        step();
        eret = 1'b1;
        step();
        eret = 1'b0;
        sb.push_back('{IVEC, 32'h0040_0200, 8'h00});
        wait_take(5, seen, cyc);
        e = sb.pop_front();
        total++;
        if (!seen || cause !== e.cause) begin
            bad++; $display("[TB] FAIL edge_second: seen=%b cause=%h required 1/%h", seen, cause, e.cause);
        end
        step();
        eret = 1'b1;
        step();
        eret = 1'b0;
        wait_take(6, seen, cyc);
        total++;
        if (seen) begin
            bad++; $display("[TB] FAIL edge_retrigger: seen=%b required 0", seen);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_irq_entry();
        test_exc_priority();
        test_kernel_mode();
        test_mask();
        test_fault_and_reset();
`ifdef IRQ_EDGE_EN
        test_edge();
`endif
        total++;
        if (sb.size() != 0) begin
            bad++; $display("[TB] FAIL scoreboard_left: entries=%0d required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
